// File: rtl/ras_link_pkg.sv
// Shared definitions for the Raspberry Pi host link: word geometry, header layout
// and the receive framing state.
package ras_link_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int WORD_W           = 32;
  localparam int NIBBLES_PER_WORD = 8;
  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'h5A5A;

  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_LEN_MSB   = 15;
  localparam int HDR_LEN_LSB   = 0;

  typedef enum logic [1:0] {IDLE, HDR, PAY} rx_state_e;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } rx_word_t;

  function automatic logic [15:0] hdr_magic(input logic [WORD_W-1:0] w);
    return w[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
  endfunction

  function automatic logic [15:0] hdr_len(input logic [WORD_W-1:0] w);
    return w[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/ras_rx_nibble_packer_if.sv
// Nibble input stream and 32-bit payload output stream of the receive packer.
interface ras_rx_nibble_packer_if;
  import ras_link_pkg::*;

  logic                rasin_valid;
  logic [NIBBLE_W-1:0] rasin_data;
  logic                rasin_ready;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   out_data;
  logic                out_last;

  modport master (output rasin_valid, rasin_data, out_ready,
                  input  rasin_ready, out_valid, out_data, out_last);
  modport slave  (input  rasin_valid, rasin_data, out_ready,
                  output rasin_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/ras_word_fifo.sv
// Registered circular-buffer FIFO with occupancy count; shared by rx and tx link sides.
module ras_word_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Idle head reads as zero so the output bus is clean after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/ras_rx_nibble_packer.sv
// Assembles rasin nibbles into words, strips/validates the frame header and queues
// payload words with a last flag for the compute input stream.
module ras_rx_nibble_packer
  import ras_link_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] HDR_MAGIC  = HDR_MAGIC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   ap_rst,
  input  logic                   ap_start,
  ras_rx_nibble_packer_if.slave  bus,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt,
  output logic                   hdr_err
);
  rx_state_e         state_q, state_d;
  logic [2:0]        nib_q, nib_d;
  logic [WORD_W-1:0] sr_q, sr_d, sr_ins;
  logic [15:0]       wcnt_q, wcnt_d, len_q, len_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              herr_q, herr_d;
  logic              rdy, acc, push, fifo_full, fifo_empty;
  rx_word_t          wr_word, head;

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    sr_d    = sr_q;
    wcnt_d  = wcnt_q;
    len_d   = len_q;
    fcnt_d  = fcnt_q;
    herr_d  = herr_q;
    rdy     = 1'b0;
    push    = 1'b0;
    frame_done = 1'b0;
    wr_word = '0;

    case (state_q)
      IDLE:    if (ap_start) state_d = HDR;
      HDR:     rdy = 1'b1;
      // Completing nibble waits for room; a pop in the same cycle does not count.
      PAY:     rdy = (nib_q != 3'd7) || !fifo_full;
      default: state_d = IDLE;
    endcase
    if (ap_rst) rdy = 1'b0;

    sr_ins = sr_q;
    sr_ins[{nib_q, 2'b00} +: NIBBLE_W] = bus.rasin_data;
    acc = bus.rasin_valid && rdy;

    if (acc) begin
      nib_d = nib_q + 3'd1;
      sr_d  = (nib_q == 3'd7) ? '0 : sr_ins;
      if (nib_q == 3'd7) begin
        if (state_q == HDR) begin
          if (hdr_magic(sr_ins) != HDR_MAGIC) begin
            herr_d = 1'b1;
          end else if (hdr_len(sr_ins) == 16'd0) begin
            frame_done = 1'b1;
            fcnt_d     = fcnt_q + 8'd1;
            state_d    = ap_start ? HDR : IDLE;
          end else begin
            len_d   = hdr_len(sr_ins);
            wcnt_d  = 16'd0;
            state_d = PAY;
          end
        end else if (state_q == PAY) begin
          push         = 1'b1;
          wcnt_d       = wcnt_q + 16'd1;
          wr_word.data = sr_ins;
          wr_word.last = (wcnt_d == len_q);
          if (wr_word.last) begin
            frame_done = 1'b1;
            fcnt_d     = fcnt_q + 8'd1;
            state_d    = ap_start ? HDR : IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      nib_q   <= '0;
      sr_q    <= '0;
      wcnt_q  <= '0;
      len_q   <= '0;
      fcnt_q  <= '0;
      herr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      sr_q    <= sr_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      fcnt_q  <= fcnt_d;
      herr_q  <= herr_d;
    end
  end

  ras_word_fifo #(.WIDTH($bits(rx_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (ap_rst),
    .push_i  (push),
    .wdata_i (wr_word),
    .pop_i   (bus.out_valid && bus.out_ready),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.rasin_ready = rdy;
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_data    = head.data;
  assign bus.out_last    = head.last;
  assign frame_cnt       = fcnt_q;
  assign hdr_err         = herr_q;
endmodule

// File: tb/tb_ras_rx_nibble_packer.sv
// Directed bench for the rasin nibble packer: framing, header errors, backpressure,
// mid-frame reset and frame counter wrap.
module tb_ras_rx_nibble_packer;
  import ras_link_pkg::*;

  logic       clk = 1'b0;
  logic       ap_rst, ap_start;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       hdr_err;

  ras_rx_nibble_packer_if bus_if();

  ras_rx_nibble_packer #(.FIFO_DEPTH(4), .HDR_MAGIC(16'h5A5A)) dut (
    .clk        (clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .bus        (bus_if),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .hdr_err    (hdr_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  int          fd_cnt = 0;
  int          wait_cyc;
  logic [32:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Sampled mid-cycle: frame_done pulses and words popped at the next edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1)
      got_q.push_back({bus_if.out_last, bus_if.out_data});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    bus_if.rasin_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_nib(input logic [3:0] d);
    bit ok;
    ok = 1'b0;
    wait_cyc = 0;
    bus_if.rasin_valid = 1'b1;
    bus_if.rasin_data  = d;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = (bus_if.rasin_ready === 1'b1);
      tick();
      if (!ok) wait_cyc++;
    end
    if (!ok) chk("nibble_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) send_nib(w[4*i +: 4]);
  endtask

  logic [31:0] w, bp_w[6];
  int fd0, n0;

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0;
    bus_if.rasin_valid = 1'b0; bus_if.rasin_data = '0; bus_if.out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_rasin_ready", bus_if.rasin_ready, 0);
    chk("rst_out_valid",   bus_if.out_valid,   0);
    chk("rst_out_data",    bus_if.out_data,    0);
    chk("rst_out_last",    bus_if.out_last,    0);
    chk("rst_frame_done",  frame_done,         0);
    chk("rst_frame_cnt",   frame_cnt,          0);
    chk("rst_hdr_err",     hdr_err,            0);
    ap_rst = 1'b0;
    tick();
    chk("idle_not_ready", bus_if.rasin_ready, 0);

    // Two-word frame
    fd0 = fd_cnt; got_q.delete();
    ap_start = 1'b1;
    send_word(32'h5A5A0002);
    w = 32'h12345678;
    for (int i = 0; i < 7; i++) send_nib(w[4*i +: 4]);
    chk("w0_not_yet_valid", bus_if.out_valid, 0);
    send_nib(w[31:28]);
    chk("w0_valid_next_cycle", bus_if.out_valid, 1);
    chk("w0_data", bus_if.out_data, 32'h12345678);
    chk("w0_last", bus_if.out_last, 0);
    send_word(32'h9ABCDEF0);
    chk("w1_valid_next_cycle", bus_if.out_valid, 1);
    chk("w1_data", bus_if.out_data, 32'h9ABCDEF0);
    chk("w1_last", bus_if.out_last, 1);
    idle(3);
    chk("f1_word_count", got_q.size(), 2);
    chk("f1_word0", got_q[0], {1'b0, 32'h12345678});
    chk("f1_word1", got_q[1], {1'b1, 32'h9ABCDEF0});
    chk("f1_frame_done_pulses", fd_cnt - fd0, 1);
    chk("f1_frame_cnt", frame_cnt, 1);

    // Empty frame
    fd0 = fd_cnt; n0 = got_q.size();
    send_word(32'h5A5A0000);
    chk("f0_frame_done_pulses", fd_cnt - fd0, 1);
    chk("f0_frame_cnt", frame_cnt, 2);
    chk("f0_back_in_hdr", bus_if.rasin_ready, 1);
    idle(2);
    chk("f0_no_output", got_q.size(), n0);
    chk("f0_out_valid", bus_if.out_valid, 0);

    // Bad header then resync
    fd0 = fd_cnt; got_q.delete();
    send_word(32'h12340003);
    chk("bad_hdr_err", hdr_err, 1);
    chk("bad_hdr_frame_cnt", frame_cnt, 2);
    send_word(32'h5A5A0001);
    send_word(32'hDEADBEEF);
    idle(3);
    chk("resync_word_count", got_q.size(), 1);
    chk("resync_word", got_q[0], {1'b1, 32'hDEADBEEF});
    chk("resync_frame_cnt", frame_cnt, 3);
    chk("resync_frame_done", fd_cnt - fd0, 1);
    chk("hdr_err_sticky", hdr_err, 1);

    // Backpressure: 6 words into a 4-deep FIFO
    got_q.delete();
    for (int i = 0; i < 6; i++) bp_w[i] = 32'hC0DE0000 + 32'(i) * 32'h00010101;
    bus_if.out_ready = 1'b0;
    send_word(32'h5A5A0006);
    for (int i = 0; i < 4; i++) send_word(bp_w[i]);
    w = bp_w[4];
    for (int i = 0; i < 7; i++) send_nib(w[4*i +: 4]);
    chk("bp_nib6_no_stall", wait_cyc, 0);
    bus_if.rasin_valid = 1'b1;
    bus_if.rasin_data  = w[31:28];
    @(negedge clk);
    chk("bp_nib7_stalled_a", bus_if.rasin_ready, 0);
    tick();
    @(negedge clk);
    chk("bp_nib7_stalled_b", bus_if.rasin_ready, 0);
    tick();
    bus_if.out_ready = 1'b1;
    send_nib(w[31:28]);
    send_word(bp_w[5]);
    idle(8);
    chk("bp_word_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("bp_word%0d", i), got_q[i], {(i == 5), bp_w[i]});
    chk("bp_frame_cnt", frame_cnt, 4);

    // Reset in the middle of payload
    got_q.delete();
    bus_if.out_ready = 1'b0;
    send_word(32'h5A5A0003);
    send_word(32'h11112222);
    w = 32'h33334444;
    for (int i = 0; i < 3; i++) send_nib(w[4*i +: 4]);
    chk("mid_one_queued", bus_if.out_valid, 1);
    ap_rst = 1'b1;
    bus_if.rasin_valid = 1'b0;
    tick();
    ap_rst = 1'b0;
    chk("mid_rst_out_valid", bus_if.out_valid, 0);
    chk("mid_rst_rasin_ready", bus_if.rasin_ready, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_hdr_err", hdr_err, 0);
    bus_if.out_ready = 1'b1;
    send_word(32'h5A5A0001);
    send_word(32'hCAFEF00D);
    idle(3);
    chk("post_rst_word_count", got_q.size(), 1);
    chk("post_rst_word", got_q[0], {1'b1, 32'hCAFEF00D});
    chk("post_rst_frame_cnt", frame_cnt, 1);

    // 256 back-to-back single-word frames
    got_q.delete(); fd0 = fd_cnt;
    for (int f = 0; f < 255; f++) begin
      send_word(32'h5A5A0001);
      send_word(32'hA5000000 | 32'(f));
    end
    idle(3);
    chk("wrap_frame_cnt_zero", frame_cnt, 0);
    send_word(32'h5A5A0001);
    send_word(32'hA50000FF);
    idle(3);
    chk("wrap_frame_cnt_one", frame_cnt, 1);
    chk("wrap_frame_done_pulses", fd_cnt - fd0, 256);
    chk("wrap_word_count", got_q.size(), 256);
    for (int f = 0; f < 256; f++)
      chk($sformatf("wrap_word%0d", f), got_q[f], {1'b1, 32'hA5000000 | 32'(f)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
